// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared state encoding and sizing helpers for the PLL reset sequencer
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    DEBOUNCE   = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } seq_state_e;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic int clamp_min(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  // Wide enough to hold the larger terminal count minus one; never less than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop single-bit synchronizer with async active-low clear
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - staged periph/core reset release gated on a debounced PLL lock
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_DELAY         = 16,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  output logic             periph_rst_n,
  output logic             core_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int SYNC_N = clamp_min(SYNC_STAGES, SYNC_STAGES_MIN);
  localparam int LOCK_N = clamp_min(LOCK_STABLE_CYCLES, 1);
  localparam int CORE_N = clamp_min(CORE_DELAY, 1);
  localparam int CW     = cnt_width(LOCK_N, CORE_N);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_N - 1);
  localparam logic [CW-1:0] CORE_LAST = CW'(CORE_N - 1);

  logic rst_ok;
  logic locked_s;

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             lost;
  logic             periph_q, core_q, ready_q;

  bit_sync #(.STAGES(SYNC_N)) u_rst_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (1'b1),
    .q_o    (rst_ok)
  );

  bit_sync #(.STAGES(SYNC_N)) u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    lost    = 1'b0;
    if (!rst_ok) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
          end
        end
        DEBOUNCE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = REL_PERIPH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        REL_PERIPH: begin
          // Lock loss outranks a software request arriving on the same edge.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            lost    = 1'b1;
          end else if (sw_rst_req) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
          end else if (cnt_q == CORE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            lost    = 1'b1;
          end else if (sw_rst_req) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
    if (lost && (loss_q != '1)) begin
      loss_d = loss_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      loss_q   <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loss_q   <= loss_d;
      periph_q <= (state_d == REL_PERIPH) || (state_d == RUN);
      core_q   <= (state_d == RUN);
      ready_q  <= (state_d == RUN);
    end
  end

  assign periph_rst_n  = periph_q;
  assign core_rst_n    = core_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer against a timeline model
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int L    = 8;
  localparam int C    = 4;
  localparam int CW   = 2;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          sw_rst_req = 1'b0;
  logic          periph_rst_n;
  logic          core_rst_n;
  logic          ready;
  logic [CW-1:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  // Model: the release sequence is a timeline anchored at the edge where debouncing began.
  int edge_k = 0;
  bit active = 1'b0;
  int start  = 0;
  int m_loss = 0;
  bit lk_q[$];

  pll_reset_sequencer #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (L),
    .CORE_DELAY         (C),
    .CNT_W              (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .periph_rst_n  (periph_rst_n),
    .core_rst_n    (core_rst_n),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW+2:0] got_vec();
    return {periph_rst_n, core_rst_n, ready, lock_loss_cnt};
  endfunction

  function automatic logic [CW+2:0] exp_vec();
    logic p;
    logic c;
    p = active && (edge_k >= start + L);
    c = active && (edge_k >= start + L + C);
    return {p, c, c, CW'(m_loss)};
  endfunction

  task automatic model_reset();
    lk_q.delete();
    active = 1'b0;
    start  = 0;
    m_loss = 0;
  endtask

  task automatic step(input bit pl, input bit sw);
    bit ls;
    bit released;
    @(negedge clk);
    pll_locked = pl;
    sw_rst_req = sw;
    @(posedge clk);
    edge_k++;
    lk_q.push_back(pl);
    ls = 1'b0;
    if (lk_q.size() > SYNC) begin
      ls = lk_q[0];
      void'(lk_q.pop_front());
    end
    released = active && (edge_k - 1 >= start + L);
    if (!active) begin
      if (ls) begin
        active = 1'b1;
        start  = edge_k;
      end
    end else if (!ls) begin
      if (released && m_loss < SAT) m_loss++;
      active = 1'b0;
    end else if (sw && released) begin
      start = edge_k;
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b0);
  endtask

  task automatic go_run();
    repeat (20) step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (got_vec() !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", got_vec(), {(CW+3){1'b0}});
    end
    apply_reset();
    checks++;
    if (got_vec() !== exp_vec() || got_vec() !== '0) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_release(input int sw_at);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, i == sw_at);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL release_model step %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
      if (i == 10 || i == 11 || i == 14 || i == 15) begin
        checks++;
        if ({periph_rst_n, core_rst_n, ready} !== {i >= 11, i >= 15, i >= 15}) begin
          errors++;
          $display("FAIL release_latency step %0d: got %b expected %b", i,
                   {periph_rst_n, core_rst_n, ready}, {i >= 11, i >= 15, i >= 15});
        end
      end
    end
  endtask

  task automatic test_sw_rst();
    logic [CW-1:0] cnt0;
    cnt0 = lock_loss_cnt;
    step(1'b1, 1'b1);
    checks++;
    if ({periph_rst_n, core_rst_n, ready} !== 3'b000 || got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL sw_rst_assert: got %b expected %b", got_vec(), exp_vec());
    end
    for (int j = 1; j <= 14; j++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({periph_rst_n, core_rst_n, lock_loss_cnt} !== {j >= 8, j >= 12, cnt0}
          || got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sw_rst_release step %0d: got %b expected %b", j, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock_loss();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, i == 5);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lock_loss_model step %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
      if (i == 2 || i == 3) begin
        checks++;
        if ({periph_rst_n, core_rst_n, ready, lock_loss_cnt} !== {{3{i == 2}}, CW'(i == 3 ? 1 : 0)}) begin
          errors++;
          $display("FAIL lock_loss_latency step %0d: got %b", i, got_vec());
        end
      end
    end
    test_release(6);
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if ({periph_rst_n, core_rst_n, ready, lock_loss_cnt} !== {3'b111, CW'(1)}) begin
      errors++;
      $display("FAIL simul_pre: got %b", got_vec());
    end
    step(1'b0, 1'b1);
    checks++;
    if ({periph_rst_n, core_rst_n, ready, lock_loss_cnt} !== {3'b000, CW'(2)} || got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL simul_edge: got %b expected %b", got_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simul_after step %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 6; i++) begin
      step(i < 5, 1'b0);
      checks++;
      if (got_vec() !== exp_vec() || periph_rst_n !== 1'b0) begin
        errors++;
        $display("FAIL glitch_hold step %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
    for (int j = 1; j <= 16; j++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({periph_rst_n, core_rst_n} !== {j >= 11, j >= 15} || got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_release step %0d: got %b expected %b", j, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int n = 1; n <= 5; n++) begin
      repeat (16) step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);
      checks++;
      if (lock_loss_cnt !== CW'((n < SAT) ? n : SAT) || got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL saturate loss %0d: got %b expected cnt %0d", n, got_vec(), (n < SAT) ? n : SAT);
      end
    end
    repeat (12) step(1'b1, 1'b0);
    checks++;
    if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
      errors++;
      $display("FAIL mid_rel_periph: got %b expected 100", {periph_rst_n, core_rst_n, ready});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", got_vec(), {(CW+3){1'b0}});
    end
    apply_reset();
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL post_async_reset: got %b expected %b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit pl;
    int hold;
    pl = 1'b0;
    for (int seg = 0; seg < 120; seg++) begin
      hold = $urandom_range(1, 30);
      pl   = ($urandom_range(0, 3) != 0) ? ~pl : pl;
      for (int h = 0; h < hold; h++) begin
        step(pl, $urandom_range(0, 15) == 0);
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random edge %0d: got %b expected %b", edge_k, got_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_release(0);
    test_sw_rst();
    test_lock_loss();
    test_simultaneous();
    test_glitch();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
